// File: rtl/matrix_line_gen_pkg.sv
// Shared types and sizes for the 3-row window producer (package morph_pkg).
package morph_pkg;
  localparam int PIX_W          = 24;
  localparam int DEF_PIC_WIDTH  = 250;
  localparam int DEF_PIC_HEIGHT = 250;
  localparam int COL_W          = 11;
  localparam int ROW_W          = 11;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

  function automatic int addr_w(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/matrix_line_gen_if.sv
// Raster-in / aligned-column-out bundle between the pixel source and matrix_line_gen.
interface matrix_line_gen_if #(parameter int WIDTH = morph_pkg::PIX_W);
  logic             valid_in;
  logic             sof_in;
  logic [WIDTH-1:0] din;
  logic             valid_out;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic [WIDTH-1:0] dout3;
  logic             eol_out;
  logic             eof_out;

  modport master (
    output valid_in, sof_in, din,
    input  valid_out, dout1, dout2, dout3, eol_out, eof_out
  );
  modport slave (
    input  valid_in, sof_in, din,
    output valid_out, dout1, dout2, dout3, eol_out, eof_out
  );
endinterface

// File: rtl/matrix_line_gen_line_delay.sv
// One line of pixel storage: combinational read, write on the clock, so a same-cycle
// access at one address returns the old contents (read-before-write).
module line_delay #(
  parameter int WIDTH = morph_pkg::PIX_W,
  parameter int DEPTH = morph_pkg::DEF_PIC_WIDTH,
  parameter int AW    = morph_pkg::addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk)
    if (we) mem_q[addr] <= wdata;
endmodule

// File: rtl/matrix_line_gen.sv
// Raster stream -> three vertically aligned row taps (r-2, r-1, r) for 3x3 morphology.
// Define BORDER_REPLICATE_EN to emit rows 0/1 with replicated top-border taps.
module matrix_line_gen
  import morph_pkg::*;
#(
  parameter int WIDTH      = PIX_W,
  parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_line_gen_if.slave   bus
);
  localparam int   AW       = addr_w(PIC_WIDTH);
  localparam col_t LAST_COL = col_t'(PIC_WIDTH - 1);
  localparam row_t LAST_ROW = row_t'(PIC_HEIGHT - 1);

  col_t             col_q, col_d, cur_col;
  row_t             row_q, row_d, cur_row;
  logic             pix, resync, emit, last_col, last_row;
  logic [WIDTH-1:0] tap_a, tap_b, nx1, nx2;
  logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;
  logic             valid_q, eol_q, eof_q;

  // sof acts in the same cycle: the pixel carrying it is (0,0) regardless of counters
  always_comb begin
    pix      = bus.valid_in;
    resync   = pix && bus.sof_in;
    cur_col  = resync ? '0 : col_q;
    cur_row  = resync ? '0 : row_q;
    last_col = (cur_col == LAST_COL);
    last_row = (cur_row == LAST_ROW);
    col_d    = col_q;
    row_d    = row_q;
    if (pix) begin
      col_d = last_col ? '0 : cur_col + col_t'(1);
      row_d = last_col ? (last_row ? '0 : cur_row + row_t'(1)) : cur_row;
    end
  end

  line_delay #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH)) u_line_a (
    .clk(clk), .we(pix), .addr(cur_col[AW-1:0]), .wdata(bus.din), .rdata(tap_a)
  );

  line_delay #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH)) u_line_b (
    .clk(clk), .we(pix), .addr(cur_col[AW-1:0]), .wdata(tap_a), .rdata(tap_b)
  );

`ifdef BORDER_REPLICATE_EN
  always_comb begin
    emit = pix;
    nx1  = tap_b;
    nx2  = tap_a;
    if (cur_row == row_t'(0)) begin
      nx1 = bus.din;
      nx2 = bus.din;
    end else if (cur_row == row_t'(1)) begin
      nx1 = tap_a;
    end
  end
`else
  // rows 0/1 still fill the line RAMs; stale RAM contents are never emitted
  always_comb begin
    emit = pix && (cur_row >= row_t'(2));
    nx1  = tap_b;
    nx2  = tap_a;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      dout1_q <= '0;
      dout2_q <= '0;
      dout3_q <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= emit;
      eol_q   <= emit && last_col;
      eof_q   <= emit && last_col && last_row;
      if (pix) begin
        dout1_q <= nx1;
        dout2_q <= nx2;
        dout3_q <= bus.din;
      end
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.eol_out   = eol_q;
  assign bus.eof_out   = eof_q;
  assign bus.dout1     = dout1_q;
  assign bus.dout2     = dout2_q;
  assign bus.dout3     = dout3_q;
endmodule

// File: tb/tb_matrix_line_gen.sv
// Randomized + directed bench for matrix_line_gen against a frame-image reference model.
module tb_matrix_line_gen;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 24;

`ifdef BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matrix_line_gen_if #(.WIDTH(DW)) bus ();

  matrix_line_gen #(.WIDTH(DW), .PIC_WIDTH(W), .PIC_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: current position and the pixels written so far in this frame
  logic [DW-1:0] img [H][W];
  int mc, mr;
  logic          exp_vo, exp_eol, exp_eof, exp_known, chk_en;
  logic [DW-1:0] exp_d1, exp_d2, exp_d3;
  int            cur_idx;

  logic [DW-1:0] cap_d1[$], cap_d2[$], cap_d3[$];
  logic          cap_eol[$], cap_eof[$];
  int            cap_idx[$], eof_idx[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_caps();
    cap_d1.delete(); cap_d2.delete(); cap_d3.delete();
    cap_eol.delete(); cap_eof.delete(); cap_idx.delete(); eof_idx.delete();
    cur_idx = -1;
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    bit emit;
    @(negedge clk);
    bus.valid_in = v;
    bus.sof_in   = s;
    bus.din      = d;
    exp_vo = 1'b0; exp_eol = 1'b0; exp_eof = 1'b0;
    if (v) begin
      cur_idx++;
      if (s) begin mc = 0; mr = 0; end
      img[mr][mc] = d;
      emit = BORDER || (mr >= 2);
      if (emit) begin
        exp_d3 = d;
        exp_d2 = (mr == 0) ? d : img[mr-1][mc];
        exp_d1 = (mr == 0) ? d : (mr == 1) ? img[0][mc] : img[mr-2][mc];
        exp_known = 1'b1;
        exp_vo  = 1'b1;
        exp_eol = (mc == W-1);
        exp_eof = (mc == W-1) && (mr == H-1);
      end else begin
        exp_known = 1'b0;
      end
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else mc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.sof_in = 1'b0;
    mc = 0; mr = 0;
    exp_vo = 1'b0; exp_eol = 1'b0; exp_eof = 1'b0;
    exp_d1 = '0; exp_d2 = '0; exp_d3 = '0; exp_known = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int first_row, input int n, input bit sof_first);
    for (int i = 0; i < n; i++) begin
      int r, c;
      r = first_row + i / W;
      c = i % W;
      step(1'b1, sof_first && (i == 0), DW'(10 * r + c));
    end
    step(1'b0, 1'b0, '0);
  endtask

  // literal expectations for one 12-pixel frame with din = 10*row + col
  task automatic check_frame(string tag);
    int n_exp, n;
    n_exp = BORDER ? H * W : (H - 2) * W;
    chk({tag, " count"}, cap_d1.size(), n_exp);
    n = (cap_d1.size() < n_exp) ? cap_d1.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      int r, c;
      logic [DW-1:0] e1, e2, e3;
      r = i / W + (BORDER ? 0 : 2);
      c = i % W;
      e3 = DW'(10 * r + c);
      e2 = (r == 0) ? e3 : DW'(10 * (r - 1) + c);
      e1 = (r == 0) ? e3 : (r == 1) ? DW'(c) : DW'(10 * (r - 2) + c);
      chk({tag, " dout1"}, cap_d1[i], e1);
      chk({tag, " dout2"}, cap_d2[i], e2);
      chk({tag, " dout3"}, cap_d3[i], e3);
      chk({tag, " eol"}, cap_eol[i], c == W-1);
      chk({tag, " eof"}, cap_eof[i], i == n_exp-1);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid_out", bus.valid_out, exp_vo);
      chk("eol_out", bus.eol_out, exp_eol);
      chk("eof_out", bus.eof_out, exp_eof);
      if (exp_known) begin
        chk("dout1", bus.dout1, exp_d1);
        chk("dout2", bus.dout2, exp_d2);
        chk("dout3", bus.dout3, exp_d3);
      end
      if (bus.valid_out === 1'b1) begin
        cap_d1.push_back(bus.dout1); cap_d2.push_back(bus.dout2); cap_d3.push_back(bus.dout3);
        cap_eol.push_back(bus.eol_out); cap_eof.push_back(bus.eof_out);
        cap_idx.push_back(cur_idx);
        if (bus.eof_out === 1'b1) eof_idx.push_back(cur_idx);
      end
    end
  end

  initial begin
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.sof_in = 1'b0; bus.din = '0;
    clear_caps();
    do_reset();
    chk_en = 1'b1;

    // 1: plain frame
    clear_caps();
    send_frame(0, H * W, 1'b0);
    check_frame("s1");

    // 2: valid toggling 1,0,1,0
    do_reset();
    clear_caps();
    for (int i = 0; i < H * W; i++) begin
      step(1'b1, 1'b0, DW'(10 * (i / W) + i % W));
      step(1'b0, 1'b0, DW'($urandom()));
    end
    step(1'b0, 1'b0, '0);
    check_frame("s2");

    // 3: back-to-back frames
    do_reset();
    clear_caps();
    send_frame(0, H * W, 1'b0);
    send_frame(0, H * W, 1'b0);
    chk("s3 count", cap_d1.size(), BORDER ? 2 * H * W : 2 * (H - 2) * W);
    if (eof_idx.size() >= 1 && cap_idx.size() > (BORDER ? H * W : (H - 2) * W))
      chk("s3 gap", cap_idx[BORDER ? H * W : (H - 2) * W] - eof_idx[0], BORDER ? 1 : 9);
    else
      chk("s3 outputs present", 0, 1);
    for (int i = 0; i < W; i++)
      chk("s3 frame2 dout1", cap_d1[cap_d1.size() - W + i], DW'(10 * (H - 3) + i));

    // 4: sof resync on 3rd pixel of row 1
    do_reset();
    for (int i = 0; i < W + 2; i++) step(1'b1, 1'b0, DW'(10 * (i / W) + i % W));
    step(1'b0, 1'b0, '0);
    clear_caps();
    send_frame(0, H * W, 1'b1);
    check_frame("s4");

    // 5: reset mid row 2
    do_reset();
    for (int i = 0; i < 2 * W + 2; i++) step(1'b1, 1'b0, DW'(10 * (i / W) + i % W));
    do_reset();
    clear_caps();
    send_frame(0, H * W, 1'b0);
    check_frame("s5");

    // random traffic with sparse resyncs and occasional reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, DW'($urandom()));
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
